tb_rd_memory_mc: RTL

// Testbench-only multi-channel streaming read memory; successor to the single-channel synthetic reader.
// One shared memory array with an external write/read port for bench preload and checkback.

---
 rtl/tb_rd_memory_mc.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/tb_rd_memory_mc.sv
// Multi-channel streaming read memory: shared array with bench write/read port and NumChan windowed readers.
// Latency: reads are combinational (0 cycles); each channel presents one beat per cycle while running.
// Backpressure: a channel holds addr/data until valid & ready; optional bubbles when TB_RD_MEM_STALL_EN is defined.
module tb_rd_memory_mc #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int MemDepth  = 1024,
  parameter int NumChan   = 2,
  parameter int CntWidth  = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [AddrWidth-1:0]           wr_addr_i,
  input  logic [DataWidth-1:0]           wr_data_i,
  input  logic                           wr_en_i,
  input  logic [AddrWidth-1:0]           rd_addr_i,
  output logic [DataWidth-1:0]           rd_data_o,
  input  logic [NumChan-1:0]             start_i,
  input  logic [NumChan-1:0]             stop_i,
  input  logic [NumChan*AddrWidth-1:0]   cfg_start_i,
  input  logic [NumChan*AddrWidth-1:0]   cfg_end_i,
  input  logic [NumChan*AddrWidth-1:0]   cfg_stride_i,
  input  logic [NumChan-1:0]             cfg_loop_en_i,
  output logic [NumChan*AddrWidth-1:0]   acc_addr_o,
  output logic [NumChan*DataWidth-1:0]   acc_data_o,
  output logic [NumChan-1:0]             acc_valid_o,
  input  logic [NumChan-1:0]             acc_ready_i,
  output logic [NumChan*CntWidth-1:0]    loop_cnt_o,
  output logic [NumChan-1:0]             done_o
);

  localparam int IdxW = $clog2(MemDepth);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [DataWidth-1:0] mem [MemDepth];

  // Single write port; reset wipes the whole array so every run starts from zeros.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MemDepth; i++) mem[i] <= '0;
    end else if (wr_en_i) begin
      mem[wr_addr_i[IdxW-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o = mem[rd_addr_i[IdxW-1:0]];

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    state_t               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [AddrWidth-1:0] win_start_q, win_start_d;
    logic [AddrWidth-1:0] win_end_q, win_end_d;
    logic [AddrWidth-1:0] stride_q, stride_d;
    logic                 loop_q, loop_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [CntWidth-1:0]  cnt_inc;
    logic                 vld;
    logic                 hs;

    // Pass counter saturates instead of wrapping back to zero.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef TB_RD_MEM_STALL_EN
    logic [15:0] lfsr_q;

    // Free-running per-channel LFSR; low two bits zero inserts a bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lfsr_q <= 16'hACE1 ^ 16'(c);
      else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign vld = (state_q == S_RUN) && (lfsr_q[1:0] != 2'b00);
`else
    assign vld = (state_q == S_RUN);
`endif

    assign hs = vld & acc_ready_i[c];

    // Channel state and the window configuration captured at start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q     <= S_IDLE;
        addr_q      <= '0;
        win_start_q <= '0;
        win_end_q   <= '0;
        stride_q    <= '0;
        loop_q      <= 1'b0;
        cnt_q       <= '0;
      end else begin
        state_q     <= state_d;
        addr_q      <= addr_d;
        win_start_q <= win_start_d;
        win_end_q   <= win_end_d;
        stride_q    <= stride_d;
        loop_q      <= loop_d;
        cnt_q       <= cnt_d;
      end
    end

    // Next state: stop beats start, start (re)loads the window, a handshake advances the address.
    always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      win_start_d = win_start_q;
      win_end_d   = win_end_q;
      stride_d    = stride_q;
      loop_d      = loop_q;
      cnt_d       = cnt_q;
      if (stop_i[c]) begin
        state_d = S_IDLE;
      end else if (start_i[c]) begin
        win_start_d = cfg_start_i[c*AddrWidth +: AddrWidth];
        win_end_d   = cfg_end_i[c*AddrWidth +: AddrWidth];
        stride_d    = cfg_stride_i[c*AddrWidth +: AddrWidth];
        loop_d      = cfg_loop_en_i[c];
        addr_d      = cfg_start_i[c*AddrWidth +: AddrWidth];
        cnt_d       = '0;
        state_d     = S_RUN;
      end else if (state_q == S_RUN && hs) begin
        if (addr_q != win_end_q) begin
          addr_d = addr_q + stride_q;
        end else begin
          cnt_d = cnt_inc;
          if (loop_q) addr_d = win_start_q;
          else        state_d = S_DONE;
        end
      end
    end

    assign acc_addr_o[c*AddrWidth +: AddrWidth] = addr_q;
    assign acc_data_o[c*DataWidth +: DataWidth] = mem[addr_q[IdxW-1:0]];
    assign acc_valid_o[c]                       = vld;
    assign loop_cnt_o[c*CntWidth +: CntWidth]   = cnt_q;
    assign done_o[c]                            = (state_q == S_DONE);
  end

endmodule
